ram_port_arbiter: RTL
=====================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter NumReq, default 2, number of requesters sharing one RAM port (>= 1).
REQ-002 Parameter NumWords, default 1024, words in the attached RAM.
REQ-003 Parameter DataWidth, default 64, data width.
REQ-004 Parameter ByteWidth, default 8, byte width; BeWidth = ceil(DataWidth/ByteWidth).
REQ-005 Parameter Latency, default 1, RAM read latency in cycles (>= 1).
REQ-006 Derived AddrWidth = (NumWords > 1) ? clog2(NumWords) : 1; IdWidth = (NumReq > 1) ? clog2(NumReq) : 1.
REQ-007 clk_i  input  1  clock; the block has one clock.
REQ-008 rst_ni  input  1  reset; asynchronous, active-low.
REQ-009 req_i  input  NumReq  per-requester request.
REQ-010 we_i  input  NumReq  per-requester write enable.
REQ-011 addr_i  input  NumReq x AddrWidth+1  per-requester word address (extra MSB permits out-of-range detection).
REQ-012 wdata_i  input  NumReq x DataWidth  per-requester write data.
REQ-013 be_i  input  NumReq x BeWidth  per-requester byte enable.
REQ-014 gnt_o  output  NumReq  grant, one-hot or zero.
REQ-015 rvalid_o  output  NumReq  read response valid, one-hot or zero.
REQ-016 rdata_o  output  DataWidth  read data, shared by all requesters, qualified by rvalid_o.
REQ-017 rerr_o  output  1  read response error (out-of-range address), qualified by rvalid_o.
REQ-018 mem_req_o, mem_we_o  output  1 each  RAM request and write enable.
REQ-019 mem_addr_o  output  AddrWidth  RAM address; mem_wdata_o  output  DataWidth; mem_be_o  output  BeWidth.
REQ-020 mem_rdata_i  input  DataWidth  RAM read data, valid Latency cycles after a read request.

Function
REQ-021 Arbitration SHALL be combinational: gnt_o[k] asserted in the same cycle as req_i[k] when k wins; a request is accepted when req_i[k] and gnt_o[k] are both high.
REQ-022 Winner SHALL be the first requesting index at or after priority pointer ptr_q, searching upward with wrap from NumReq-1 to 0.
REQ-023 On every accepted request ptr_q SHALL become (winner+1) mod NumReq; without acceptance ptr_q holds.
REQ-024 At most one request SHALL be accepted per cycle; no gnt_o when req_i is all zero.
REQ-025 Accepted in-range request (addr < NumWords): mem_req_o=1, mem_we_o/addr/wdata/be driven from winner, same cycle.
REQ-026 Accepted out-of-range request: mem_req_o=0; writes dropped silently; reads produce an error response.
REQ-027 When no request is accepted, mem_req_o=0 and mem_we_o=0; other mem_* outputs are don't-care.
REQ-028 Response pipeline: Latency stages of {valid, id, err}; stage input is valid only for accepted reads; writes enter no entry.
REQ-029 rvalid_o[id] SHALL assert exactly Latency cycles after acceptance of the read, for one cycle.
REQ-030 Responses SHALL return in acceptance order; back-to-back reads yield back-to-back rvalid_o pulses.
REQ-031 rdata_o = mem_rdata_i when pipeline output valid and err=0; rdata_o = 0 and rerr_o=1 when err=1.
REQ-032 rerr_o and rdata_o SHALL be 0 when no response is valid.
REQ-033 Requester may drop req_i without acceptance; no state changes for that requester.
REQ-034 NumReq = 1: gnt_o = req_i, ptr_q constant 0.
REQ-035 Same-cycle acceptance and response delivery to the same requester SHALL both occur.

Reset
REQ-036 On rst_ni low, asynchronously: ptr_q = 0, all pipeline valid bits = 0, id/err = 0.
REQ-037 During and after reset until the first acceptance: gnt_o=0 unless requested, rvalid_o=0, rerr_o=0, rdata_o=0, mem_req_o=0.
REQ-038 Reset mid-operation SHALL discard all in-flight responses; no rvalid_o after release for requests accepted before reset.

Verification
REQ-039 NumReq=2, Latency=1: req_i=2'b11 reads addr 5/6 for 4 cycles -> gnt_o 01,10,01,10; rvalid_o same pattern one cycle later with RAM data of 5,6,5,6.
REQ-040 Write req 0 addr 3 data 0xA5A5, be all ones, then read req 1 addr 3 -> mem write seen once, rvalid_o=2'b10 one cycle after read with rdata_o=0xA5A5, no rvalid for the write.
REQ-041 NumWords=1024, read addr 1024 by req 1 -> gnt_o[1]=1, mem_req_o=0, Latency cycles later rvalid_o[1]=1, rerr_o=1, rdata_o=0.
REQ-042 Latency=3, three back-to-back reads from req 0 then 1 then 0 -> rvalid_o 01,10,01 in cycles 3,4,5 in order.
REQ-043 Latency=2, read accepted, rst_ni pulsed low next cycle -> no rvalid_o after release, ptr_q=0 (req_i=11 grants req 0 first).
REQ-044 Single requester req 1 continuous -> gnt_o[1] every cycle, full throughput, ptr_q toggles correctly without starving req 0 when it joins.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin sharing of one RAM port among NumReq requesters,
// with an in-order read response pipeline that tracks the RAM read latency.
module ram_port_arbiter #(
  parameter int unsigned NumReq     = 2,
  parameter int unsigned NumWords   = 1024,
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned ByteWidth  = 8,
  parameter int unsigned Latency    = 1,
  localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth,
  localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  localparam int unsigned IdWidth   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumReq-1:0]                   req_i,
  input  logic [NumReq-1:0]                   we_i,
  input  logic [NumReq-1:0][AddrWidth:0]      addr_i,
  input  logic [NumReq-1:0][DataWidth-1:0]    wdata_i,
  input  logic [NumReq-1:0][BeWidth-1:0]      be_i,
  output logic [NumReq-1:0]                   gnt_o,
  output logic [NumReq-1:0]                   rvalid_o,
  output logic [DataWidth-1:0]                rdata_o,
  output logic                                rerr_o,
  output logic                                mem_req_o,
  output logic                                mem_we_o,
  output logic [AddrWidth-1:0]                mem_addr_o,
  output logic [DataWidth-1:0]                mem_wdata_o,
  output logic [BeWidth-1:0]                  mem_be_o,
  input  logic [DataWidth-1:0]                mem_rdata_i
);

  localparam int unsigned AddrWidthX = AddrWidth + 1;

  logic [IdWidth-1:0]   ptr_q, ptr_d;
  logic                 hit_hi, hit_any;
  logic [IdWidth-1:0]   id_hi, id_any;
  logic                 accept;
  logic [IdWidth-1:0]   win_id;
  logic                 win_we;
  logic [AddrWidth:0]   win_addr;
  logic [DataWidth-1:0] win_wdata;
  logic [BeWidth-1:0]   win_be;
  logic                 win_in_range;

  logic                 pipe_vld_d;
  logic [IdWidth-1:0]   pipe_id_d;
  logic                 pipe_err_d;
  logic [Latency-1:0]               vld_q;
  logic [Latency-1:0][IdWidth-1:0]  id_q;
  logic [Latency-1:0]               err_q;

  // Winner search: lowest requester at/above the pointer, else lowest overall (wrap).
  always_comb begin
    hit_hi  = 1'b0;
    hit_any = 1'b0;
    id_hi   = '0;
    id_any  = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (req_i[i] && !hit_hi && (i >= 32'(ptr_q))) begin
        hit_hi = 1'b1;
        id_hi  = IdWidth'(i);
      end
      if (req_i[i] && !hit_any) begin
        hit_any = 1'b1;
        id_any  = IdWidth'(i);
      end
    end
    accept = hit_any;
    win_id = hit_hi ? id_hi : id_any;
  end

  // Grant vector and selection of the winner's request fields.
  always_comb begin
    gnt_o     = '0;
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    win_be    = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (win_id == IdWidth'(i)) begin
        gnt_o[i]  = accept;
        win_we    = we_i[i];
        win_addr  = addr_i[i];
        win_wdata = wdata_i[i];
        win_be    = be_i[i];
      end
    end
  end

  // Out-of-range accesses never reach the RAM; reads among them return an error.
  always_comb begin
    win_in_range = (win_addr < AddrWidthX'(NumWords));
    mem_req_o    = accept & win_in_range;
    mem_we_o     = accept & win_in_range & win_we;
    mem_addr_o   = win_addr[AddrWidth-1:0];
    mem_wdata_o  = win_wdata;
    mem_be_o     = win_be;
    pipe_vld_d   = accept & ~win_we;
    pipe_id_d    = win_id;
    pipe_err_d   = ~win_in_range;
  end

  // Next pointer: one past the accepted winner, wrapping at NumReq.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (win_id == IdWidth'(NumReq - 1)) ? '0 : win_id + IdWidth'(1);
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Response pipeline, one stage per cycle of RAM read latency.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      id_q  <= '0;
      err_q <= '0;
    end else begin
      vld_q[0] <= pipe_vld_d;
      id_q[0]  <= pipe_id_d;
      err_q[0] <= pipe_err_d;
      for (int unsigned s = 1; s < Latency; s++) begin
        vld_q[s] <= vld_q[s-1];
        id_q[s]  <= id_q[s-1];
        err_q[s] <= err_q[s-1];
      end
    end
  end

  // Response delivery: one-hot valid, data only for error-free reads.
  always_comb begin
    rvalid_o = '0;
    rerr_o   = 1'b0;
    rdata_o  = '0;
    if (vld_q[Latency-1]) begin
      for (int unsigned i = 0; i < NumReq; i++) begin
        rvalid_o[i] = (id_q[Latency-1] == IdWidth'(i));
      end
      rerr_o = err_q[Latency-1];
      if (!err_q[Latency-1]) begin
        rdata_o = mem_rdata_i;
      end
    end
  end

endmodule
